// File: rtl/fft_pkg.sv
// Shared types and helpers for the radix-2 DIT FFT address sequencer and its index unit.
package fft_pkg;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        WAIT_RES,
        WRITE
    } state_t;

    localparam logic [1:0] SLOT_A_RE = 2'd0;
    localparam logic [1:0] SLOT_A_IM = 2'd1;
    localparam logic [1:0] SLOT_B_RE = 2'd2;
    localparam logic [1:0] SLOT_B_IM = 2'd3;

    // Real/imag words are interleaved, so the RAM needs one address bit more than the sample index.
    function automatic int fft_addr_w(input int log2_n);
        return log2_n + 1;
    endfunction

endpackage

// File: rtl/fft_bfly_index.sv
// Maps (stage, butterfly) to the two operand sample indices and the twiddle ROM index.
module fft_bfly_index #(
    parameter int LOG2_N = 9
) (
    input  logic [$clog2(LOG2_N)-1:0] s,
    input  logic [LOG2_N-2:0]         k,
    output logic [LOG2_N-1:0]         a,
    output logic [LOG2_N-1:0]         b,
    output logic [LOG2_N-2:0]         twiddle_idx
);
    localparam int SW = $clog2(LOG2_N);
    localparam logic [SW-1:0] S_LAST = SW'(LOG2_N - 1);

    logic [LOG2_N-1:0] kx;
    logic [LOG2_N-1:0] half;
    logic [LOG2_N-1:0] pos;
    logic [LOG2_N-1:0] grp;
    logic [SW-1:0]     shamt;

    always_comb begin
        kx    = {1'b0, k};
        half  = {{(LOG2_N-1){1'b0}}, 1'b1} << s;
        pos   = kx & (half - 1'b1);
        grp   = kx >> s;
        a     = ((grp << s) << 1) + pos;
        b     = a + half;
        // pos < 2^s, so it always fits in the twiddle width before the shift.
        shamt = S_LAST - s;
        twiddle_idx = pos[LOG2_N-2:0] << shamt;
    end

endmodule

// File: rtl/fft_addr_sequencer.sv
// Walks every stage/butterfly of an in-place radix-2 DIT FFT and emits operand read
// (and optional write-back) RAM addresses under valid/ready backpressure.
module fft_addr_sequencer
    import fft_pkg::*;
#(
    parameter int LOG2_N    = 9,
    parameter bit WRITEBACK = 1,
    parameter int ADDR_W    = fft_addr_w(LOG2_N)
) (
    input  logic                      clk,
    input  logic                      nrst,
    input  logic                      start,
    input  logic                      abort,
    input  logic                      addr_ready,
    input  logic                      result_valid,
    output logic [ADDR_W-1:0]         addr,
    output logic                      addr_valid,
    output logic                      addr_is_b,
    output logic                      addr_is_imag,
    output logic                      addr_is_write,
    output logic [LOG2_N-2:0]         twiddle_idx,
    output logic [$clog2(LOG2_N)-1:0] stage,
    output logic                      busy,
    output logic                      done
);
    localparam int SW = $clog2(LOG2_N);
    localparam int KW = LOG2_N - 1;
    localparam logic [SW-1:0] S_LAST = SW'(LOG2_N - 1);
    localparam logic [KW-1:0] K_LAST = '1;

    state_t            state, n_state;
    logic [SW-1:0]     s, n_s;
    logic [KW-1:0]     k, n_k;
    logic [1:0]        slot, n_slot;
    logic              n_valid, n_write, n_busy, n_done;
    logic              hs;
    logic [LOG2_N-1:0] idx_a, idx_b;
    logic [KW-1:0]     tw;

    assign hs    = addr_valid && addr_ready;
    assign stage = s;

    // Index unit looks at the next counters so the address registers line up with them.
    fft_bfly_index #(.LOG2_N(LOG2_N)) u_index (
        .s           (n_s),
        .k           (n_k),
        .a           (idx_a),
        .b           (idx_b),
        .twiddle_idx (tw)
    );

    always_comb begin
        n_state = state;
        n_s     = s;
        n_k     = k;
        n_slot  = slot;
        n_valid = addr_valid;
        n_write = addr_is_write;
        n_busy  = busy;
        n_done  = 1'b0;
        if (abort) begin
            n_state = IDLE;
            n_s     = '0;
            n_k     = '0;
            n_slot  = SLOT_A_RE;
            n_valid = 1'b0;
            n_write = 1'b0;
            n_busy  = 1'b0;
        end else begin
            unique case (state)
                IDLE: if (start) begin
                    n_state = READ;
                    n_s     = '0;
                    n_k     = '0;
                    n_slot  = SLOT_A_RE;
                    n_valid = 1'b1;
                    n_write = 1'b0;
                    n_busy  = 1'b1;
                end
                READ, WRITE: if (hs) begin
                    if (slot != SLOT_B_IM) begin
                        n_slot = slot + 2'd1;
                    end else if (state == READ && WRITEBACK) begin
                        n_state = WAIT_RES;
                        n_slot  = SLOT_A_RE;
                        n_valid = 1'b0;
                    end else begin
                        n_state = READ;
                        n_slot  = SLOT_A_RE;
                        n_write = 1'b0;
                        if (k != K_LAST) begin
                            n_k = k + KW'(1);
                        end else if (s != S_LAST) begin
                            n_k = '0;
                            n_s = s + SW'(1);
                        end else begin
                            n_state = IDLE;
                            n_k     = '0;
                            n_s     = '0;
                            n_valid = 1'b0;
                            n_busy  = 1'b0;
                            n_done  = 1'b1;
                        end
                    end
                end
                WAIT_RES: if (result_valid) begin
                    n_state = WRITE;
                    n_slot  = SLOT_A_RE;
                    n_valid = 1'b1;
                    n_write = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state         <= IDLE;
            s             <= '0;
            k             <= '0;
            slot          <= SLOT_A_RE;
            addr          <= '0;
            addr_valid    <= 1'b0;
            addr_is_b     <= 1'b0;
            addr_is_imag  <= 1'b0;
            addr_is_write <= 1'b0;
            twiddle_idx   <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
        end else begin
            state         <= n_state;
            s             <= n_s;
            k             <= n_k;
            slot          <= n_slot;
            addr          <= ADDR_W'({n_slot[1] ? idx_b : idx_a, n_slot[0]});
            addr_valid    <= n_valid;
            addr_is_b     <= n_slot[1];
            addr_is_imag  <= n_slot[0];
            addr_is_write <= n_write;
            twiddle_idx   <= tw;
            busy          <= n_busy;
            done          <= n_done;
        end
    end

endmodule
